// File: rtl/gate_bist_pkg.sv
// rtl/gate_bist_pkg.sv - shared types and truth-table constants for the gate BIST controller
package gate_bist_pkg;

  localparam int VEC_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bit i is the expected gate output for input vector {a,b} = i.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_bist_timer.sv
// rtl/gate_bist_timer.sv - per-vector settle counter; expire marks the last settle cycle
module gate_bist_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  logic [7:0] cnt;

  assign expire = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (load || expire) begin
      cnt <= 8'd0;
    end else if (enable) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/gate_bist_ctrl.sv
// rtl/gate_bist_ctrl.sv - exhaustive self-test sequencer for one 2-input gate
// Optional: GATE_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = 4'b0111,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         PASSES        = 1,
  parameter int         ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec
);

  localparam logic [3:0]       LAST_PASS = 4'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_e           state;
  logic [VEC_W-1:0] vec;
  logic [3:0]       pass_cnt;
  logic             launch;
  logic             expire;
  logic             mismatch;
  logic             stop_now;

  assign launch   = ((state == IDLE) || (state == DONE)) && start;
  assign mismatch = (state == CHECK) && (y_in !== TRUTH_TABLE[vec]);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  gate_bist_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (launch),
    .enable (state == APPLY),
    .expire (expire)
  );

  assign busy = (state == APPLY) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      pass_cnt  <= 4'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      err_count <= '0;
      fail_vec  <= 2'b00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= APPLY;
            vec       <= '0;
            pass_cnt  <= 4'd0;
            err_count <= '0;
            fail_vec  <= 2'b00;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
          end
        end
        APPLY: begin
          if (expire) state <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
            // A zero count means this is the first mismatch of the run.
            if (err_count == '0) fail_vec <= vec;
          end
          if (stop_now) begin
            state <= DONE;
            {a_out, b_out} <= 2'b00;
          end else if (vec != 2'd3) begin
            state <= APPLY;
            vec   <= vec + 2'd1;
            {a_out, b_out} <= vec + 2'd1;
          end else if (pass_cnt != LAST_PASS) begin
            state    <= APPLY;
            vec      <= '0;
            pass_cnt <= pass_cnt + 4'd1;
            {a_out, b_out} <= 2'b00;
          end else begin
            state <= DONE;
            {a_out, b_out} <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb/tb_gate_bist_ctrl.sv - randomized and directed checks of gate_bist_ctrl against a sweep model
module tb_gate_bist_ctrl;

  localparam logic [3:0] NAND_TT = 4'b0111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [3];
  logic       y     [3];
  logic       a     [3];
  logic       b     [3];
  logic       busy  [3];
  logic       done  [3];
  logic       pass  [3];
  logic [3:0] err   [3];
  logic [1:0] fv    [3];
  logic [3:0] gfn   [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Each DUT drives its own emulated gate whose function is gfn.
  for (genvar gi = 0; gi < 3; gi++) begin : g_gate
    assign y[gi] = gfn[gi][{a[gi], b[gi]}];
  end

  gate_bist_ctrl #(.TRUTH_TABLE(4'b0111), .SETTLE_CYCLES(2), .PASSES(1), .ERR_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a_out(a[0]), .b_out(b[0]), .y_in(y[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err[0]), .fail_vec(fv[0]));

  gate_bist_ctrl #(.TRUTH_TABLE(4'b0111), .SETTLE_CYCLES(1), .PASSES(2), .ERR_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a_out(a[1]), .b_out(b[1]), .y_in(y[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err[1]), .fail_vec(fv[1]));

  gate_bist_ctrl #(.TRUTH_TABLE(4'b0111), .SETTLE_CYCLES(3), .PASSES(5), .ERR_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .a_out(a[2]), .b_out(b[2]), .y_in(y[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err[2]), .fail_vec(fv[2]));

  function automatic int passes_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 5;
  endfunction

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sweep model: walk all 4*PASSES vectors and tally disagreements with the NAND table.
  task automatic model(input int i, input logic [3:0] g, output int ncyc, output int nerr,
                       output logic [1:0] fvx);
    int p, s, total, first;
    p = passes_of(i);
    s = settle_of(i);
    total = 0;
    first = -1;
    for (int n = 0; n < 4 * p; n++) begin
      if (g[n % 4] !== NAND_TT[n % 4]) begin
        total++;
        if (first < 0) first = n;
      end
    end
    ncyc = 4 * p * (s + 1);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    if (first >= 0) begin
      ncyc  = (first + 1) * (s + 1);
      total = 1;
    end
`endif
    nerr = (total > 15) ? 15 : total;
    fvx  = (first < 0) ? 2'b00 : 2'(first % 4);
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk(tag, {busy[i], done[i], pass[i], a[i], b[i], err[i], fv[i]}, 32'd0);
  endtask

  task automatic run(input int i, input logic [3:0] g, input bit poke);
    int ncyc, nerr, s;
    logic [1:0] fvx;
    logic [1:0] ev;
    model(i, g, ncyc, nerr, fvx);
    s = settle_of(i);
    gfn[i] = g;
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) @(negedge clk);
      ev = 2'((k / (s + 1)) % 4);
      chk("run_seq", {busy[i], done[i], a[i], b[i]}, {1'b1, 1'b0, ev});
      start[i] = (poke && k == 2 && k < ncyc - 1);
    end
    @(negedge clk);
    start[i] = 1'b0;
    chk("done_flags", {busy[i], done[i], pass[i], a[i], b[i]}, {1'b0, 1'b1, (nerr == 0), 2'b00});
    chk("err_count", err[i], nerr);
    chk("fail_vec", fv[i], fvx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      gfn[i]   = NAND_TT;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle(i, "reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle(i, "idle_after_reset");

    run(0, NAND_TT, 1'b1);
    run(0, 4'b1111, 1'b0);
    run(1, 4'b1000, 1'b0);
    run(2, 4'b1000, 1'b0);
    run(1, NAND_TT, 1'b1);

    // Reset while vector 2 is in APPLY, then a clean rerun.
    gfn[0] = 4'b0000;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_reset_vec", {busy[0], a[0], b[0]}, {1'b1, 2'b10});
    #2 rst_n = 1'b0;
    #1 chk_idle(0, "mid_run_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle(0, "after_reset_release");
    run(0, NAND_TT, 1'b0);

    for (int r = 0; r < 10; r++) begin
      run($urandom_range(0, 2), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
